// File: rtl/gerador_de_prioridade_pkg.sv
// rtl/gerador_de_prioridade_pkg.sv - priority code values and press sequence mapping
//   prio_t     : 2-bit priority code driven onto P
//   next_prio  : code that follows a given one on each accepted button press

package gerador_de_prioridade_pkg;

    typedef enum logic [1:0] {
        PRIO_OFF = 2'b00,
        PRIO_A   = 2'b10,
        PRIO_B   = 2'b01,
        PRIO_AB  = 2'b11
    } prio_t;

    // Press order: off -> A only -> B only -> A or B -> off
    function automatic prio_t next_prio(input prio_t p);
        prio_t n;
        case (p)
            PRIO_OFF: n = PRIO_A;
            PRIO_A:   n = PRIO_B;
            PRIO_B:   n = PRIO_AB;
            default:  n = PRIO_OFF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/gerador_de_prioridade_filtro_botao.sv
// rtl/gerador_de_prioridade_filtro_botao.sv - button synchronizer, debouncer and press detector
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   BTN   : raw push-button, asynchronous to clk, 1 = pressed
//   press : high for one cycle after the debounced level rises

module filtro_botao #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic BTN,
    output logic press
);

    // The counter clears on the same edge the level toggles, so the toggle
    // fires when it holds DEBOUNCE_CYCLES-1 and a further mismatch arrives.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             btn_s;
    logic             level;
    logic             level_prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_1 <= BTN;
            btn_s  <= sync_1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (btn_s == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    // Rising edge only; a debounced release produces nothing.
    assign press = level & ~level_prev;

endmodule

// File: rtl/gerador_de_prioridade.sv
// rtl/gerador_de_prioridade.sv - registered priority code P from a debounced button or direct load
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high
//   BTN     : raw push-button, 1 = pressed
//   LOCK    : 1 = freeze P, presses and loads are dropped
//   SET_EN  : 1 = load SET_VAL into P this cycle
//   SET_VAL : direct-load value
//   P       : priority code shared by all functionality selectors
//   CHANGED : one-cycle pulse in the cycle P takes a new value

module gerador_de_prioridade
    import gerador_de_prioridade_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       BTN,
    input  logic       LOCK,
    input  logic       SET_EN,
    input  logic [1:0] SET_VAL,
    output logic [1:0] P,
    output logic       CHANGED
);

    logic  press;
    prio_t state_q;
    prio_t state_d;
    logic  changed_q;

    filtro_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_filtro (
        .clk  (clk),
        .reset(reset),
        .BTN  (BTN),
        .press(press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PRIO_OFF;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            changed_q <= (state_d != state_q);
        end
    end

    // Lock beats load beats press; anything not taken is dropped, not queued.
    always_comb begin
        state_d = state_q;
        if (!LOCK) begin
            if (SET_EN) begin
                state_d = prio_t'(SET_VAL);
            end else if (press) begin
                state_d = next_prio(state_q);
            end
        end
    end

    assign P       = state_q;
    assign CHANGED = changed_q;

endmodule

// File: tb/tb_gerador_de_prioridade.sv
// tb/tb_gerador_de_prioridade.sv - directed self-checking bench for gerador_de_prioridade

module tb_gerador_de_prioridade;

    logic       clk;
    logic       reset;
    logic       BTN;
    logic       LOCK;
    logic       SET_EN;
    logic [1:0] SET_VAL;
    logic [1:0] P;
    logic       CHANGED;

    int n_vec;
    int n_err;
    int chg_cnt;

    gerador_de_prioridade #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .BTN    (BTN),
        .LOCK   (LOCK),
        .SET_EN (SET_EN),
        .SET_VAL(SET_VAL),
        .P      (P),
        .CHANGED(CHANGED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1ns after the last one, and count CHANGED pulses.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (CHANGED === 1'b1) chg_cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(1);
        chg_cnt = 0;
    endtask

    task automatic press_release();
        BTN = 1'b1;
        run(10);
        BTN = 1'b0;
        run(10);
    endtask

    logic [1:0] exp_seq [5];

    initial begin
        n_vec   = 0;
        n_err   = 0;
        chg_cnt = 0;
        reset   = 1'b0;
        BTN     = 1'b0;
        LOCK    = 1'b0;
        SET_EN  = 1'b0;
        SET_VAL = 2'b00;
        exp_seq[0] = 2'b10;
        exp_seq[1] = 2'b01;
        exp_seq[2] = 2'b11;
        exp_seq[3] = 2'b00;
        exp_seq[4] = 2'b10;

        // 1: reset, then a clean press with exact latency
        run(2);
        reset = 1'b1;
        run(2);
        check_val("rst_p", 8'(P), 8'(2'b00));
        check_val("rst_chg", 8'(CHANGED), 8'd0);
        reset = 1'b0;
        run(1);
        chg_cnt = 0;
        BTN = 1'b1;
        run(6);
        check_val("lat_e6_p", 8'(P), 8'(2'b00));
        check_val("lat_e6_chgcnt", 8'(chg_cnt), 8'd0);
        run(1);
        check_val("lat_e7_p", 8'(P), 8'(2'b10));
        check_val("lat_e7_chg", 8'(CHANGED), 8'd1);
        run(1);
        check_val("lat_e8_chg", 8'(CHANGED), 8'd0);
        run(12);
        check_val("hold_p", 8'(P), 8'(2'b10));
        check_val("hold_chgcnt", 8'(chg_cnt), 8'd1);
        BTN = 1'b0;
        run(10);

        // 2: five presses walk the whole sequence and wrap
        do_reset();
        for (int k = 0; k < 5; k++) begin
            press_release();
            check_val($sformatf("seq%0d_p", k), 8'(P), 8'(exp_seq[k]));
        end
        check_val("seq_chgcnt", 8'(chg_cnt), 8'd5);

        // 3: bounce and a short glitch are rejected
        do_reset();
        for (int k = 0; k < 4; k++) begin
            BTN = (k % 2 == 0);
            run(1);
        end
        BTN = 1'b0;
        run(10);
        check_val("bounce_p", 8'(P), 8'(2'b00));
        check_val("bounce_chgcnt", 8'(chg_cnt), 8'd0);
        BTN = 1'b1;
        run(3);
        BTN = 1'b0;
        run(10);
        check_val("glitch_p", 8'(P), 8'(2'b00));
        check_val("glitch_chgcnt", 8'(chg_cnt), 8'd0);

        // 4: direct load wins over a simultaneous press
        press_release();
        check_val("ld_pre_p", 8'(P), 8'(2'b10));
        BTN = 1'b1;
        run(6);
        SET_EN  = 1'b1;
        SET_VAL = 2'b11;
        run(1);
        SET_EN = 1'b0;
        check_val("ld_p", 8'(P), 8'(2'b11));
        check_val("ld_chg", 8'(CHANGED), 8'd1);
        run(8);
        check_val("ld_press_lost", 8'(P), 8'(2'b11));
        BTN = 1'b0;
        run(10);
        chg_cnt = 0;
        SET_EN  = 1'b1;
        SET_VAL = 2'b11;
        run(1);
        SET_EN = 1'b0;
        check_val("ld_same_p", 8'(P), 8'(2'b11));
        check_val("ld_same_chg", 8'(CHANGED), 8'd0);

        // 5: LOCK drops both press and load; held button needs release + re-press
        chg_cnt = 0;
        LOCK = 1'b1;
        BTN  = 1'b1;
        run(6);
        SET_EN  = 1'b1;
        SET_VAL = 2'b01;
        run(1);
        SET_EN = 1'b0;
        run(5);
        check_val("lock_p", 8'(P), 8'(2'b11));
        check_val("lock_chgcnt", 8'(chg_cnt), 8'd0);
        LOCK = 1'b0;
        run(10);
        check_val("unlock_held_p", 8'(P), 8'(2'b11));
        check_val("unlock_held_chgcnt", 8'(chg_cnt), 8'd0);
        BTN = 1'b0;
        run(10);
        press_release();
        check_val("unlock_repress_p", 8'(P), 8'(2'b00));
        check_val("unlock_repress_chgcnt", 8'(chg_cnt), 8'd1);

        // 6: asynchronous reset mid-debounce, then a full fresh debounce
        press_release();
        check_val("ar_pre_p", 8'(P), 8'(2'b10));
        BTN = 1'b1;
        run(4);
        #2;
        reset = 1'b1;
        #1;
        check_val("ar_async_p", 8'(P), 8'(2'b00));
        check_val("ar_async_chg", 8'(CHANGED), 8'd0);
        #2;
        reset = 1'b0;
        chg_cnt = 0;
        run(6);
        check_val("ar_e6_p", 8'(P), 8'(2'b00));
        check_val("ar_e6_chgcnt", 8'(chg_cnt), 8'd0);
        run(1);
        check_val("ar_e7_p", 8'(P), 8'(2'b10));
        check_val("ar_e7_chg", 8'(CHANGED), 8'd1);
        BTN = 1'b0;
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
